// File: rtl/fetch_redirect_unit.sv
// Fetch/redirect front end: fetches opcode words with an optional immediate word and inserts
// flush bubbles after a taken jump. Optional macro FETCH_REDIRECT_COUNT_EN adds redirect_count.
module fetch_redirect_unit #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump_occured,
  input  logic [15:0] jump_target,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] instruction,
  output logic [15:0] immediate,
  output logic [15:0] instr_pc,
  output logic        instr_valid
`ifdef FETCH_REDIRECT_COUNT_EN
  ,
  output logic [15:0] redirect_count
`endif
);

  typedef enum logic [1:0] {StFetch, StImm, StFlush} state_e;

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [15:0] pc_q;
  logic [15:0] op_q;
  logic [15:0] op_pc_q;
  logic [15:0] pc_inc;

  assign imem_addr = pc_q;
  assign pc_inc    = pc_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFetch;
      cnt_q       <= 3'd0;
      pc_q        <= RESET_PC;
      op_q        <= 16'h0000;
      op_pc_q     <= 16'h0000;
      instruction <= 16'h0000;
      immediate   <= 16'h0000;
      instr_pc    <= 16'h0000;
      instr_valid <= 1'b0;
    end else if (jump_occured) begin
      // Redirect wins over stall and drops any half-fetched instruction.
      state_q     <= StFlush;
      cnt_q       <= FlushLoad;
      pc_q        <= jump_target;
      op_q        <= 16'h0000;
      op_pc_q     <= 16'h0000;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        StFetch: begin
          pc_q <= pc_inc;
          if (imem_data[15]) begin
            op_q        <= imem_data;
            op_pc_q     <= pc_q;
            instr_valid <= 1'b0;
            state_q     <= StImm;
          end else begin
            instruction <= imem_data;
            immediate   <= 16'h0000;
            instr_pc    <= pc_q;
            instr_valid <= 1'b1;
          end
        end
        StImm: begin
          pc_q        <= pc_inc;
          instruction <= op_q;
          immediate   <= imem_data;
          instr_pc    <= op_pc_q;
          instr_valid <= 1'b1;
          state_q     <= StFetch;
        end
        StFlush: begin
          instr_valid <= 1'b0;
          cnt_q       <= cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_q <= StFetch;
          end
        end
        default: begin
          state_q     <= StFetch;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_REDIRECT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_count <= 16'h0000;
    end else if (jump_occured) begin
      redirect_count <= redirect_count + 16'd1;
    end
  end
`endif

endmodule
